// File: rtl/uart_mmio_pkg.sv
// Shared definitions for the UART transmit MMIO bridge: register offsets,
// STATUS bit positions, output FSM encoding and the default window base.
package uart_mmio_pkg;

  localparam logic [31:0] UART_BASE_DEFAULT = 32'h1000_0000;

  localparam logic [2:0] TXDATA_OFF = 3'h0;
  localparam logic [2:0] STATUS_OFF = 3'h4;

  localparam int STAT_FULL_BIT  = 0;
  localparam int STAT_EMPTY_BIT = 1;
  localparam int STAT_BUSY_BIT  = 2;
  localparam int STAT_OVF_BIT   = 3;
  localparam int STAT_CNT_LSB   = 8;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } tx_state_e;

endpackage

// File: rtl/uart_tx_mmio_bridge_if.sv
// Bus between the memory_access stage / uart_tx and the transmit bridge.
// slave  : the bridge side.
// master : the core and serialiser side (drives addresses, strobes, ready).
interface uart_tx_mmio_bridge_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] addr;
  logic            mem_write;
  logic            mem_read;
  logic [XLEN-1:0] write_data;
  logic [2:0]      funct3;
  logic            hit;
  logic [XLEN-1:0] read_data;
  logic [7:0]      tx_data;
  logic            tx_data_valid;
  logic            tx_data_ready;
  logic            irq_tx_empty;

  modport slave (
    input  addr, mem_write, mem_read, write_data, funct3, tx_data_ready,
    output hit, read_data, tx_data, tx_data_valid, irq_tx_empty
  );

  modport master (
    output addr, mem_write, mem_read, write_data, funct3, tx_data_ready,
    input  hit, read_data, tx_data, tx_data_valid, irq_tx_empty
  );
endinterface

// File: rtl/uart_tx_mmio_bridge_sync_fifo.sv
// Single-clock FIFO with flush. Head entry is visible on o_rdata without a
// read strobe; i_pop just advances past it.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic                   i_flush,
  input  logic [WIDTH-1:0]       i_wdata,
  output logic [WIDTH-1:0]       o_rdata,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rptr];
  // a push into a full FIFO is only legal when the head leaves in the same cycle
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  // storage write; contents need no reset since pointers gate visibility
  always_ff @(posedge i_clk) begin
    if (w_do_push && !i_flush) begin
      r_mem[r_wptr] <= i_wdata;
    end
  end

  // pointer and occupancy tracking
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + AW'(1);
      if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/uart_tx_mmio_bridge.sv
// Memory-mapped UART transmit bridge. Decodes an 8-byte register window,
// queues stored bytes and presents them to uart_tx over valid/ready.
//
// state      | meaning
// ST_IDLE    | nothing presented, tx_data_valid low
// ST_PRESENT | tx_data held stable with tx_data_valid high until ready
module uart_tx_mmio_bridge
  import uart_mmio_pkg::*;
#(
  parameter int              XLEN           = 32,
  parameter int              FIFO_DEPTH     = 16,
  parameter logic [XLEN-1:0] UART_BASE_ADDR = XLEN'(UART_BASE_DEFAULT)
) (
  input logic                 clk,
  input logic                 rst,
  uart_tx_mmio_bridge_if.slave bus
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  tx_state_e       r_state;
  logic [7:0]      r_tx_data;
  logic            r_tx_valid;
  logic            r_ovf;
  logic            r_irq;

  logic            w_hit;
  logic [2:0]      w_off;
  logic            w_wr_tx;
  logic            w_wr_st;
  logic            w_flush;
  logic            w_clr_ovf;
  logic            w_xfer;
  logic            w_pop;
  logic            w_push_ok;
  logic            w_idle_nxt;
  logic [CW-1:0]   w_cnt_nxt;
  logic [7:0]      w_fifo_rdata;
  logic            w_fifo_full;
  logic            w_fifo_empty;
  logic [CW-1:0]   w_fifo_count;
  logic [XLEN-1:0] w_status;
  logic            w_unused;

  assign w_off = bus.addr[2:0];
  assign w_hit = (bus.addr[XLEN-1:3] == UART_BASE_ADDR[XLEN-1:3]) &&
                 (bus.addr[1:0] == 2'b00) && (bus.mem_read || bus.mem_write);

  assign w_wr_tx   = w_hit && bus.mem_write && (w_off == TXDATA_OFF);
  assign w_wr_st   = w_hit && bus.mem_write && (w_off == STATUS_OFF);
  assign w_flush   = w_wr_st && bus.write_data[0];
  assign w_clr_ovf = w_wr_st && bus.write_data[3];

  // the head is taken whenever the output slot is free or being freed; a flush
  // in the same cycle wins so nothing queued before it ever gets presented
  assign w_xfer    = (r_state == ST_PRESENT) && bus.tx_data_ready;
  assign w_pop     = !w_flush && !w_fifo_empty && ((r_state == ST_IDLE) || w_xfer);
  assign w_push_ok = w_wr_tx && (!w_fifo_full || w_pop);

  assign w_idle_nxt = !w_pop && ((r_state == ST_IDLE) || w_xfer);
  assign w_cnt_nxt  = w_flush ? '0 : (w_fifo_count + CW'(w_push_ok) - CW'(w_pop));

  // only the low byte is ever queued, whatever the store width
  assign w_unused = ^{bus.funct3, bus.write_data[XLEN-1:8]};

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_push  (w_push_ok),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .i_wdata (bus.write_data[7:0]),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  // STATUS word assembly
  always_comb begin
    w_status = '0;
    w_status[STAT_FULL_BIT]              = w_fifo_full;
    w_status[STAT_EMPTY_BIT]             = w_fifo_empty;
    w_status[STAT_BUSY_BIT]              = r_tx_valid;
    w_status[STAT_OVF_BIT]               = r_ovf;
    w_status[STAT_CNT_LSB +: CW]         = w_fifo_count;
  end

  assign bus.hit       = w_hit;
  assign bus.read_data = (w_hit && bus.mem_read && (w_off == STATUS_OFF)) ? w_status : '0;

  // output FSM: present the FIFO head and hold it until uart_tx takes it
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_tx_data  <= 8'h00;
      r_tx_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_tx_data  <= w_fifo_rdata;
            r_tx_valid <= 1'b1;
            r_state    <= ST_PRESENT;
          end
        end
        ST_PRESENT: begin
          if (w_xfer) begin
            if (w_pop) begin
              r_tx_data <= w_fifo_rdata;
            end else begin
              r_tx_valid <= 1'b0;
              r_state    <= ST_IDLE;
            end
          end
        end
        default: begin
          r_tx_valid <= 1'b0;
          r_state    <= ST_IDLE;
        end
      endcase
    end
  end

  // sticky overflow flag, cleared by writing 1 to its STATUS bit
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_clr_ovf) begin
      r_ovf <= 1'b0;
    end else if (w_wr_tx && !w_push_ok) begin
      r_ovf <= 1'b1;
    end
  end

  // empty interrupt reflects the state the bridge settles into at this edge
  always_ff @(posedge clk) begin
    if (rst) begin
      r_irq <= 1'b1;
    end else begin
      r_irq <= (w_cnt_nxt == '0) && w_idle_nxt;
    end
  end

  assign bus.tx_data       = r_tx_data;
  assign bus.tx_data_valid = r_tx_valid;
  assign bus.irq_tx_empty  = r_irq;
endmodule

// File: tb/tb_uart_tx_mmio_bridge.sv
// Self-checking bench for uart_tx_mmio_bridge: decode vector table, directed
// corner sequences and a randomised run against a queue-based model.
module tb_uart_tx_mmio_bridge;
  localparam int          DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h1000_0000;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  uart_tx_mmio_bridge_if #(.XLEN(32)) bus_if ();

  uart_tx_mmio_bridge #(
    .XLEN           (32),
    .FIFO_DEPTH     (DEPTH),
    .UART_BASE_ADDR (BASE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  // reference model state
  logic [7:0]  q[$];
  logic [7:0]  m_tx;
  bit          m_valid;
  bit          m_ovf;
  bit          m_irq;
  logic        last_hit;
  logic [31:0] last_rd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_hit(input logic [31:0] a, input bit rd, input bit wr);
    logic [1:0] lo;
    lo = a[1:0];
    return ((a >> 3) == (BASE >> 3)) && (lo == 2'b00) && (rd || wr);
  endfunction

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s = 32'h0;
    s[0]    = (q.size() == DEPTH);
    s[1]    = (q.size() == 0);
    s[2]    = m_valid;
    s[3]    = m_ovf;
    s[15:8] = 8'(q.size());
    return s;
  endfunction

  task automatic model_reset();
    q.delete();
    m_tx    = 8'h00;
    m_valid = 1'b0;
    m_ovf   = 1'b0;
    m_irq   = 1'b1;
  endtask

  task automatic model_step(input bit r, input bit wr, input bit rd,
                            input logic [31:0] a, input logic [31:0] wd, input bit rdy);
    bit h, flush, clr, push, xfer, popn, acc;
    logic [2:0] off;
    if (r) begin
      model_reset();
      return;
    end
    off   = a[2:0];
    h     = m_hit(a, rd, wr);
    flush = h && wr && (off == 3'h4) && wd[0];
    clr   = h && wr && (off == 3'h4) && wd[3];
    push  = h && wr && (off == 3'h0);
    xfer  = m_valid && rdy;
    popn  = !flush && (q.size() > 0) && (!m_valid || xfer);
    acc   = push && ((q.size() < DEPTH) || popn);
    if (flush) q.delete();
    if (popn) begin
      m_tx    = q.pop_front();
      m_valid = 1'b1;
    end else if (xfer) begin
      m_valid = 1'b0;
    end
    if (acc) q.push_back(wd[7:0]);
    else if (push) m_ovf = 1'b1;
    if (clr) m_ovf = 1'b0;
    m_irq = (q.size() == 0) && !m_valid;
  endtask

  // one bus cycle: combinational checks before the edge, registered after it
  task automatic do_cycle(input bit r, input bit wr, input bit rd, input logic [31:0] a,
                          input logic [31:0] wd, input logic [2:0] f3, input bit rdy);
    logic [31:0] exp_rd;
    logic [2:0]  off;
    bit          eh;
    rst                  = r;
    bus_if.mem_write     = wr;
    bus_if.mem_read      = rd;
    bus_if.addr          = a;
    bus_if.write_data    = wd;
    bus_if.funct3        = f3;
    bus_if.tx_data_ready = rdy;
    #1;
    off    = a[2:0];
    eh     = m_hit(a, rd, wr);
    exp_rd = (eh && rd && (off == 3'h4)) ? m_status() : 32'h0;
    last_hit = bus_if.hit;
    last_rd  = bus_if.read_data;
    check("hit", {31'h0, bus_if.hit}, {31'h0, eh});
    check("read_data", bus_if.read_data, exp_rd);
    @(posedge clk);
    model_step(r, wr, rd, a, wd, rdy);
    #1;
    check("tx_data_valid", {31'h0, bus_if.tx_data_valid}, {31'h0, m_valid});
    check("tx_data", {24'h0, bus_if.tx_data}, {24'h0, m_tx});
    check("irq_tx_empty", {31'h0, bus_if.irq_tx_empty}, {31'h0, m_irq});
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] wd, input logic [2:0] f3, input bit rdy);
    do_cycle(1'b0, 1'b1, 1'b0, a, wd, f3, rdy);
  endtask

  task automatic load(input logic [31:0] a, input bit rdy);
    do_cycle(1'b0, 1'b0, 1'b1, a, 32'h0, 3'b010, rdy);
  endtask

  task automatic idle(input bit rdy);
    do_cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000, rdy);
  endtask

  typedef struct {
    bit          wr;
    bit          rd;
    logic [31:0] a;
    logic [31:0] wd;
    bit          exp_hit;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vt[10];

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    rst = 1'b1;
    bus_if.mem_write = 1'b0; bus_if.mem_read = 1'b0; bus_if.addr = '0;
    bus_if.write_data = '0; bus_if.funct3 = '0; bus_if.tx_data_ready = 1'b0;

    // reset state
    do_cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 1'b0);
    do_cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 1'b0);
    load(BASE + 32'h4, 1'b0);
    check("reset_status", last_rd, 32'h0000_0002);
    check("reset_valid", {31'h0, bus_if.tx_data_valid}, 32'h0);
    check("reset_irq", {31'h0, bus_if.irq_tx_empty}, 32'h1);

    // decode table on an empty bridge
    vt[0] = '{0, 1, BASE + 32'h4, 32'h0, 1, 32'h2};
    vt[1] = '{0, 1, BASE + 32'h0, 32'h0, 1, 32'h0};
    vt[2] = '{0, 1, BASE + 32'h1, 32'h0, 0, 32'h0};
    vt[3] = '{0, 1, BASE + 32'h8, 32'h0, 0, 32'h0};
    vt[4] = '{0, 1, BASE + 32'h6, 32'h0, 0, 32'h0};
    vt[5] = '{0, 1, BASE - 32'h4, 32'h0, 0, 32'h0};
    vt[6] = '{0, 0, BASE + 32'h4, 32'h0, 0, 32'h0};
    vt[7] = '{1, 0, BASE + 32'h4, 32'h0, 1, 32'h0};
    vt[8] = '{0, 1, 32'h2000_0004, 32'h0, 0, 32'h0};
    vt[9] = '{0, 1, BASE + 32'h5, 32'h0, 0, 32'h0};
    for (int i = 0; i < 10; i++) begin
      do_cycle(1'b0, vt[i].wr, vt[i].rd, vt[i].a, vt[i].wd, 3'b010, 1'b0);
      check($sformatf("vec%0d_hit", i), {31'h0, last_hit}, {31'h0, vt[i].exp_hit});
      check($sformatf("vec%0d_rd", i), last_rd, vt[i].exp_rd);
    end

    // single byte, held while ready stays low
    store(BASE, 32'hFFFF_FF41, 3'b000, 1'b0);
    idle(1'b0);
    for (int i = 0; i < 10; i++) begin
      check("hold_data", {24'h0, bus_if.tx_data}, 32'h41);
      check("hold_valid", {31'h0, bus_if.tx_data_valid}, 32'h1);
      idle(1'b0);
    end
    idle(1'b1);
    check("single_done_valid", {31'h0, bus_if.tx_data_valid}, 32'h0);
    check("single_done_irq", {31'h0, bus_if.irq_tx_empty}, 32'h1);

    // fill, overflow, in-order drain
    for (int i = 0; i < 16; i++) store(BASE, 32'(i), 3'b010, 1'b0);
    load(BASE + 32'h4, 1'b0);
    check("fill_status", last_rd, 32'h0000_0F04);
    store(BASE, 32'h10, 3'b010, 1'b0);
    store(BASE, 32'h11, 3'b010, 1'b0);
    load(BASE + 32'h4, 1'b0);
    check("ovf_status", last_rd, 32'h0000_100D);
    for (int i = 0; i < 17; i++) begin
      check("drain_data", {24'h0, bus_if.tx_data}, 32'(i));
      check("drain_valid", {31'h0, bus_if.tx_data_valid}, 32'h1);
      idle(1'b1);
    end
    check("drain_end_valid", {31'h0, bus_if.tx_data_valid}, 32'h0);
    store(BASE + 32'h4, 32'h8, 3'b010, 1'b0);
    load(BASE + 32'h4, 1'b0);
    check("ovf_cleared", last_rd, 32'h0000_0002);

    // push while full with a simultaneous pop
    for (int i = 0; i < 17; i++) store(BASE, 32'h20 + 32'(i), 3'b000, 1'b0);
    load(BASE + 32'h4, 1'b0);
    check("full_status", last_rd, 32'h0000_1005);
    store(BASE, 32'h31, 3'b000, 1'b1);
    load(BASE + 32'h4, 1'b0);
    check("full_push_pop", last_rd, 32'h0000_1005);
    check("full_push_pop_data", {24'h0, bus_if.tx_data}, 32'h21);
    for (int i = 0; i < 20; i++) idle(1'b1);
    check("full_drained_irq", {31'h0, bus_if.irq_tx_empty}, 32'h1);

    // flush keeps the presented byte
    for (int i = 1; i <= 5; i++) store(BASE, 32'(i), 3'b000, 1'b0);
    load(BASE + 32'h4, 1'b0);
    check("pre_flush_status", last_rd, 32'h0000_0404);
    store(BASE + 32'h4, 32'h1, 3'b010, 1'b0);
    load(BASE + 32'h4, 1'b0);
    check("post_flush_status", last_rd, 32'h0000_0006);
    check("post_flush_data", {24'h0, bus_if.tx_data}, 32'h01);
    idle(1'b1);
    check("flush_done_valid", {31'h0, bus_if.tx_data_valid}, 32'h0);
    check("flush_done_irq", {31'h0, bus_if.irq_tx_empty}, 32'h1);

    // misaligned / out of window, then reset mid-transfer
    store(BASE + 32'h1, 32'h55, 3'b000, 1'b0);
    check("misaligned_hit", {31'h0, last_hit}, 32'h0);
    load(BASE + 32'h8, 1'b0);
    check("outside_hit", {31'h0, last_hit}, 32'h0);
    check("outside_rd", last_rd, 32'h0);
    load(BASE + 32'h4, 1'b0);
    check("untouched_status", last_rd, 32'h0000_0002);
    store(BASE, 32'h77, 3'b000, 1'b0);
    store(BASE, 32'h78, 3'b000, 1'b0);
    check("pre_rst_valid", {31'h0, bus_if.tx_data_valid}, 32'h1);
    do_cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 1'b0);
    check("rst_valid", {31'h0, bus_if.tx_data_valid}, 32'h0);
    check("rst_irq", {31'h0, bus_if.irq_tx_empty}, 32'h1);
    load(BASE + 32'h4, 1'b0);
    check("rst_status", last_rd, 32'h0000_0002);

    // randomised traffic against the model
    for (int n = 0; n < 1500; n++) begin
      bit          rdy;
      bit          r;
      int unsigned op;
      logic [31:0] wd;
      logic [31:0] bad [4];
      bad[0] = BASE + 32'h1; bad[1] = BASE + 32'h8; bad[2] = BASE + 32'h6; bad[3] = BASE - 32'h8;
      rdy = (n < 750) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      r   = ($urandom_range(0, 199) == 0);
      op  = $urandom_range(0, 9);
      wd  = $urandom();
      if (r) begin
        do_cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000, rdy);
      end else if (op <= 3) begin
        store(BASE, wd, 3'($urandom_range(0, 2)), rdy);
      end else if (op == 4) begin
        wd = wd & ~32'h9;
        if ($urandom_range(0, 7) == 0) wd[0] = 1'b1;
        if ($urandom_range(0, 3) == 0) wd[3] = 1'b1;
        store(BASE + 32'h4, wd, 3'b010, rdy);
      end else if (op <= 6) begin
        load(BASE + 32'h4, rdy);
      end else if (op == 7) begin
        load(BASE, rdy);
      end else if (op == 8) begin
        do_cycle(1'b0, wd[0], ~wd[0], bad[$urandom_range(0, 3)], wd, 3'b000, rdy);
      end else begin
        idle(rdy);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/uart_tx_mmio_bridge.md
Name: uart_tx_mmio_bridge

Overview:
- Memory-mapped UART transmit bridge between the memory_access stage and the uart_tx instance in the single-cycle core top level.
- Decodes stores/loads to a small register window, buffers outgoing bytes in a FIFO and drives uart_tx through a valid/ready handshake.
- Lets the core issue back-to-back byte stores without stalling while the serialiser runs at baud rate.

Parameters:
- XLEN, 32, datapath width of address/data buses.
- FIFO_DEPTH, 16, byte FIFO entries; power of two, >= 2.
- UART_BASE_ADDR, 32'h1000_0000, base of 8-byte register window; 8-byte aligned.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous reset, active-high
- addr  in  XLEN  effective address (EX result)
- mem_write  in  1  store strobe for this cycle
- mem_read  in  1  load strobe for this cycle
- write_data  in  XLEN  store data (rs2)
- funct3  in  3  load/store width code
- hit  out  1  access addresses this block (combinational)
- read_data  out  XLEN  load data (combinational)
- tx_data  out  8  byte to uart_tx
- tx_data_valid  out  1  tx_data is valid
- tx_data_ready  in  1  uart_tx accepts byte
- irq_tx_empty  out  1  FIFO empty and no byte presented (registered)

Behaviour:
- Register map (offset from UART_BASE_ADDR): 0x0 TXDATA (W: push write_data[7:0]; R: 0); 0x4 STATUS (R: bit0 full, bit1 empty, bit2 busy (tx_data_valid), bit3 overflow, bits[15:8] count; upper bits 0. W: bit0=1 flush FIFO, bit3=1 clears overflow (W1C)).
- hit = (addr[XLEN-1:3] == base[XLEN-1:3]) && addr[1:0]==0 && (mem_read|mem_write). Misaligned accesses: hit=0, no side effect.
- funct3 sb/sh/sw all push only write_data[7:0]; loads of any width return the full 32-bit word; no sign extension inside the block.
- read_data = 0 when hit=0 or mem_read=0; combinational, same cycle.
- Reset: FIFO empty, count 0, overflow 0, tx_data 8'h00, tx_data_valid 0, irq_tx_empty 1, FSM IDLE. Reset mid-transfer drops the presented byte and all queued bytes.
- Push: store to TXDATA accepted at clock edge if count < FIFO_DEPTH OR a pop occurs in the same cycle; otherwise dropped and overflow set to 1 (sticky).
- Output FSM, two states:
  - IDLE: tx_data_valid=0. If FIFO non-empty at edge: pop head into tx_data, go PRESENT.
  - PRESENT: tx_data_valid=1, tx_data stable. Transfer occurs at edge where tx_data_ready=1. On transfer: if FIFO non-empty, pop next into tx_data, stay PRESENT (1 byte/cycle throughput); else go IDLE.
- Latency: store to TXDATA at edge k with empty FIFO and IDLE -> tx_data_valid high after edge k+1.
- Count wrap: read/write pointers are log2(FIFO_DEPTH) bits and wrap; count is log2(FIFO_DEPTH)+1 bits; STATUS count zero-extended.
- Flush: empties FIFO at that edge; a byte already in PRESENT is not retracted and completes normally.
- Simultaneous push and pop at full: both happen, count unchanged, no overflow.
- irq_tx_empty registered: 1 when next-state FIFO empty and next-state FSM IDLE.

Decomposition:
- Shared package uart_mmio_pkg: register offsets (TXDATA_OFF=0, STATUS_OFF=4), STATUS bit indices, FSM state encoding (IDLE, PRESENT), default base address.
- One sub-module: sync_fifo (WIDTH=8, DEPTH=FIFO_DEPTH; push/pop/full/empty/count; sync active-high rst). Bridge holds address decode, status logic, output FSM.

Test Plan:
- Reset, then load STATUS -> read_data 32'h0000_0002 (empty), tx_data_valid 0, irq_tx_empty 1.
- sb 8'h41 to base+0, tx_data_ready=0 -> next cycle tx_data=8'h41, valid=1, held 10 cycles stable; ready=1 one cycle -> valid 0 next cycle, irq_tx_empty 1.
- 16 sw to TXDATA (bytes 0x00..0x0F) with ready=0 -> after first pop count 15; 2 more stores -> one accepted, then count 16 full; next dropped, STATUS bit3=1; drain with ready=1 -> bytes 0x00..0x10 in order one per cycle, 0x11 never appears.
- FIFO full with ready=1 and store same cycle -> store accepted, count stays 16, overflow stays 0.
- 5 bytes queued, 0x01 presented, store 32'h1 to STATUS -> count 0, presented byte still completes, then IDLE; store 32'h8 -> overflow cleared.
- sb to base+1 and lw from base+8 -> hit 0, read_data 0, count unchanged; assert rst during PRESENT -> valid 0 and count 0 after that edge.
